// File: rtl/intr_sched_pkg.sv
// Shared definitions for the interrupt scheduler: register offsets, FSM states,
// the "no cause" marker and a lowest-set-bit helper used for priority selection.
package intr_sched_pkg;

    localparam logic [2:0] OFF_MASK   = 3'd0;
    localparam logic [2:0] OFF_PEND   = 3'd1;
    localparam logic [2:0] OFF_CLR    = 3'd2;
    localparam logic [2:0] OFF_CAUSE  = 3'd3;
    localparam logic [2:0] OFF_PERIOD = 3'd4;
    localparam logic [2:0] OFF_LOST   = 3'd5;

    localparam logic [7:0] CAUSE_NONE = 8'hFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    // Bit 0 is highest priority, so scan downwards and keep the last hit.
    function automatic logic [2:0] lowest_index(input logic [7:0] vec);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (vec[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/intr_sched_timer.sv
// Periodic event source: prescaler plus tick counter, emitting a one-cycle
// pulse every PRESCALE*period clocks. period=0 stops and clears it.
module intr_timer #(
    parameter int PRESCALE = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] period,
    input  logic       period_wr,
    output logic       tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] pre_cnt;
    logic [7:0]    tick_cnt;
    logic          wrap;

    assign wrap = (pre_cnt == PW'(PRESCALE - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_cnt  <= '0;
            tick_cnt <= '0;
            tick     <= 1'b0;
        end else if (period_wr || (period == 8'd0)) begin
            pre_cnt  <= '0;
            tick_cnt <= '0;
            tick     <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (wrap) begin
                pre_cnt <= '0;
                if (tick_cnt == period - 8'd1) begin
                    tick_cnt <= '0;
                    tick     <= 1'b1;
                end else begin
                    tick_cnt <= tick_cnt + 8'd1;
                end
            end else begin
                pre_cnt <= pre_cnt + PW'(1);
            end
        end
    end

endmodule

// File: rtl/intr_sched.sv
// Interrupt scheduler for KCPSM6: edge-detects sources, latches pending, masks,
// grants one prioritized interrupt at a time. Optional LOST counter: INTR_SCHED_LOST_CNT_EN.
module intr_sched
    import intr_sched_pkg::*;
#(
    parameter int         NUM_SRC   = 4,
    parameter logic [7:0] BASE_ADDR = 8'h20,
    parameter int         PRESCALE  = 100000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [7:0]         port_id,
    input  logic [7:0]         data_in,
    input  logic               write_strobe,
    input  logic               read_strobe,
    output logic [7:0]         data_out,
    output logic               interrupt,
    input  logic               interrupt_ack
);

    localparam int NS = NUM_SRC + 1;

    state_t         state, state_next;
    logic [NUM_SRC-1:0] irq_q;
    logic [NS-1:0]  pending, mask, events, masked, clr_bits;
    logic [7:0]     cause, period, rd_data;
    logic           sel, wr, grant, ack_clear, intr_next, timer_tick;
    logic [2:0]     off;

    assign sel    = (port_id[7:3] == BASE_ADDR[7:3]);
    assign off    = port_id[2:0];
    assign wr     = write_strobe & sel;
    assign events = {timer_tick, irq_src & ~irq_q};
    assign masked = pending & mask;

    intr_timer #(.PRESCALE(PRESCALE)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .period    (period),
        .period_wr (wr && off == OFF_PERIOD),
        .tick      (timer_tick)
    );

    always_comb begin
        state_next = state;
        intr_next  = interrupt;
        grant      = 1'b0;
        ack_clear  = 1'b0;
        case (state)
            IDLE: if (|masked) begin
                grant      = 1'b1;
                intr_next  = 1'b1;
                state_next = ASSERT;
            end
            ASSERT: if (interrupt_ack) begin
                ack_clear  = 1'b1;
                intr_next  = 1'b0;
                state_next = HOLDOFF;
            end
            HOLDOFF: state_next = IDLE;
            default: begin
                intr_next  = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        clr_bits = '0;
        if (wr && off == OFF_CLR) clr_bits = data_in[NS-1:0];
        if (ack_clear) clr_bits = clr_bits | ({{(NS-1){1'b0}}, 1'b1} << cause[2:0]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            interrupt <= 1'b0;
            irq_q     <= '0;
            pending   <= '0;
            mask      <= '0;
            cause     <= CAUSE_NONE;
            period    <= 8'd0;
            data_out  <= 8'd0;
        end else begin
            state     <= state_next;
            interrupt <= intr_next;
            irq_q     <= irq_src;
            // New events are OR'd in after the clear so a simultaneous event wins.
            pending   <= (pending & ~clr_bits) | events;
            data_out  <= rd_data;
            if (grant) cause <= {5'd0, lowest_index(8'(masked))};
            if (wr && off == OFF_MASK) mask <= data_in[NS-1:0];
            if (wr && off == OFF_PERIOD) period <= data_in;
        end
    end

`ifdef INTR_SCHED_LOST_CNT_EN
    logic [7:0] lost_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lost_cnt <= 8'd0;
        end else if (wr && off == OFF_LOST) begin
            lost_cnt <= 8'd0;
        end else if ((|(events & pending)) && lost_cnt != 8'hFF) begin
            lost_cnt <= lost_cnt + 8'd1;
        end
    end
`endif

    always_comb begin
        rd_data = 8'd0;
        if (sel) begin
            case (off)
                OFF_MASK:   rd_data = 8'(mask);
                OFF_PEND:   rd_data = 8'(pending);
                OFF_CAUSE:  rd_data = cause;
                OFF_PERIOD: rd_data = period;
`ifdef INTR_SCHED_LOST_CNT_EN
                OFF_LOST:   rd_data = lost_cnt;
`endif
                default:    rd_data = 8'd0;
            endcase
        end
    end

    // Reads carry no side effects; the strobe is accepted only for interface completeness.
    logic unused_rd;
    assign unused_rd = read_strobe;

endmodule

// File: tb/tb_intr_sched.sv
// Self-checking bench for intr_sched: directed scenarios followed by random traffic,
// every cycle compared against a cycle-level behavioural model of the register block.
module tb_intr_sched;
    import intr_sched_pkg::*;

    localparam int         NUM_SRC  = 4;
    localparam int         PRESCALE = 10;
    localparam logic [7:0] BASE     = 8'h20;

    // Clock / reset and DUT
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] irq_src = '0;
    logic [7:0] port_id = '0, data_in = '0;
    logic       write_strobe = 1'b0, read_strobe = 1'b0, interrupt_ack = 1'b0;
    logic [7:0] data_out;
    logic       interrupt;

    always #5 clk = ~clk;

    intr_sched #(.NUM_SRC(NUM_SRC), .BASE_ADDR(BASE), .PRESCALE(PRESCALE)) dut (
        .clk(clk), .rst(rst), .irq_src(irq_src), .port_id(port_id), .data_in(data_in),
        .write_strobe(write_strobe), .read_strobe(read_strobe), .data_out(data_out),
        .interrupt(interrupt), .interrupt_ack(interrupt_ack)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Reference model: register contents, grant bookkeeping and a cycle count since
    // the last PERIOD write from which timer events follow arithmetically.
    logic [4:0] m_pend, m_mask;
    logic [7:0] m_cause, m_period, m_lost, m_dout;
    logic [3:0] m_prev;
    logic       m_intr;
    int         m_phase;   // 0 waiting for work, 1 interrupt raised, 2 cool-down cycle
    int         m_n;

    task automatic model_reset();
        m_pend = '0; m_mask = '0; m_cause = 8'hFF; m_period = '0; m_lost = '0;
        m_dout = '0; m_prev = '0; m_intr = 1'b0; m_phase = 0; m_n = 0;
    endtask

    function automatic logic [7:0] m_read(input logic [7:0] a);
        if (a[7:3] != BASE[7:3]) return 8'd0;
        case (a[2:0])
            3'd0: return {3'b0, m_mask};
            3'd1: return {3'b0, m_pend};
            3'd3: return m_cause;
            3'd4: return m_period;
`ifdef INTR_SCHED_LOST_CNT_EN
            3'd5: return m_lost;
`endif
            default: return 8'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock: update the model from the inputs now applied, then compare.
    task automatic step();
        logic [4:0] ev, clr, work;
        logic       pulse, wr, collide;
        int         idx;
        pulse = (m_period != 0) && (m_n > 0) && ((m_n % (PRESCALE * int'(m_period))) == 0);
        ev    = {pulse, irq_src & ~m_prev};
        wr    = write_strobe && (port_id[7:3] == BASE[7:3]);
        clr   = (wr && port_id[2:0] == 3'd2) ? data_in[4:0] : 5'd0;
        m_dout = m_read(port_id);
        work  = m_pend & m_mask;
        if (m_phase == 0) begin
            if (work != 0) begin
                idx = 0;
                while (!work[idx]) idx++;
                m_cause = 8'(idx);
                m_intr  = 1'b1;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (interrupt_ack) begin
                m_intr  = 1'b0;
                clr     = clr | (5'b1 << m_cause);
                m_phase = 2;
            end
        end else begin
            m_phase = 0;
        end
        collide = |(ev & m_pend);
        m_pend  = (m_pend & ~clr) | ev;
        if (wr && port_id[2:0] == 3'd5) m_lost = 8'd0;
        else if (collide && m_lost != 8'hFF) m_lost = m_lost + 8'd1;
        if (wr && port_id[2:0] == 3'd0) m_mask = data_in[4:0];
        if (wr && port_id[2:0] == 3'd4) begin
            m_period = data_in;
            m_n = 0;
        end else if (m_period != 0) begin
            m_n++;
        end
        m_prev = irq_src;
        @(posedge clk);
        #1;
        cyc++;
        check("interrupt", {7'b0, interrupt}, {7'b0, m_intr});
        check("data_out", data_out, m_dout);
    endtask

    // Driver tasks
    task automatic wr_reg(input logic [2:0] off, input logic [7:0] d);
        port_id = BASE + {5'b0, off};
        data_in = d;
        write_strobe = 1'b1;
        step();
        write_strobe = 1'b0;
    endtask

    task automatic rd_reg(input string tag, input logic [2:0] off, input logic [7:0] exp);
        port_id = BASE + {5'b0, off};
        read_strobe = 1'b1;
        step();
        read_strobe = 1'b0;
        check(tag, data_out, exp);
    endtask

    task automatic wait_intr(input int budget, output int waited);
        waited = 0;
        while (!interrupt && waited < budget) begin
            step();
            waited++;
        end
        check("intr_wait", {7'b0, interrupt}, 8'd1);
    endtask

    task automatic ack();
        interrupt_ack = 1'b1;
        step();
        interrupt_ack = 1'b0;
        check("ack_drop", {7'b0, interrupt}, 8'd0);
    endtask

    initial begin
        int w, t1, t2;
        model_reset();

        // Reset with sources toggling: everything held at zero.
        rst = 1'b0;
        repeat (6) begin
            irq_src = 4'($urandom);
            @(posedge clk);
            #1;
            check("rst_intr", {7'b0, interrupt}, 8'd0);
            check("rst_dout", data_out, 8'd0);
        end
        irq_src = '0;
        rst = 1'b1;

        rd_reg("rb_mask", 3'd0, 8'h00);
        rd_reg("rb_pend", 3'd1, 8'h00);
        rd_reg("rb_clr", 3'd2, 8'h00);
        rd_reg("rb_cause", 3'd3, 8'hFF);
        rd_reg("rb_period", 3'd4, 8'h00);
        rd_reg("rb_lost", 3'd5, 8'h00);
        rd_reg("rb_6", 3'd6, 8'h00);
        rd_reg("rb_7", 3'd7, 8'h00);
        wr_reg(3'd0, 8'h1F);
        rd_reg("mask_1f", 3'd0, 8'h1F);
        port_id = 8'h18;
        step();
        check("outside", data_out, 8'h00);

        // Single event on source 0.
        wr_reg(3'd0, 8'h01);
        irq_src = 4'b0001;
        step();
        rd_reg("single_pend", 3'd1, 8'h01);
        check("single_intr", {7'b0, interrupt}, 8'd1);
        rd_reg("single_cause", 3'd3, 8'h00);
        ack();
        rd_reg("single_pend_clr", 3'd1, 8'h00);
        irq_src = '0;
        step();

        // Priority: sources 1 and 3 together.
        wr_reg(3'd0, 8'h0F);
        irq_src = 4'b1010;
        step();
        wait_intr(5, w);
        rd_reg("prio_first", 3'd3, 8'h01);
        ack();
        wait_intr(6, w);
        check("prio_gap", {7'b0, w >= 1}, 8'd1);
        rd_reg("prio_second", 3'd3, 8'h03);
        ack();
        irq_src = '0;
        repeat (2) step();

        // Timer at PERIOD=3: events every 3*PRESCALE cycles.
        wr_reg(3'd0, 8'h10);
        wr_reg(3'd4, 8'h03);
        wait_intr(40, w);
        t1 = cyc;
        rd_reg("timer_cause", 3'd3, 8'h04);
        ack();
        wait_intr(40, w);
        t2 = cyc;
        check("timer_interval", 8'(t2 - t1), 8'(3 * PRESCALE));
        ack();
        wr_reg(3'd4, 8'h00);
        repeat (80) step();
        check("timer_off", {7'b0, interrupt}, 8'd0);

        // Set wins over a simultaneous CLR.
        wr_reg(3'd0, 8'h00);
        irq_src = 4'b0010;
        port_id = BASE + 8'd2;
        data_in = 8'h02;
        write_strobe = 1'b1;
        step();
        write_strobe = 1'b0;
        rd_reg("set_wins", 3'd1, 8'h02);
        irq_src = '0;
        wr_reg(3'd2, 8'h1F);
        rd_reg("clr_all", 3'd1, 8'h00);

        // Repeated events on a masked source collapse; collisions counted when enabled.
        wr_reg(3'd5, 8'h00);
        repeat (5) begin
            irq_src[2] = 1'b1;
            step();
            irq_src[2] = 1'b0;
            step();
        end
        rd_reg("collapse_pend", 3'd1, 8'h04);
`ifdef INTR_SCHED_LOST_CNT_EN
        rd_reg("lost_4", 3'd5, 8'h04);
`else
        rd_reg("lost_absent", 3'd5, 8'h00);
`endif
        wr_reg(3'd5, 8'h00);
        rd_reg("lost_clr", 3'd5, 8'h00);
        wr_reg(3'd2, 8'h1F);

        // Reset in the middle of an asserted interrupt drops it asynchronously.
        wr_reg(3'd0, 8'h01);
        irq_src = 4'b0001;
        step();
        step();
        check("pre_rst_intr", {7'b0, interrupt}, 8'd1);
        #3 rst = 1'b0;
        #1 check("async_rst_intr", {7'b0, interrupt}, 8'd0);
        model_reset();
        irq_src = '0;
        @(posedge clk);
        #1 rst = 1'b1;
        rd_reg("post_rst_mask", 3'd0, 8'h00);
        rd_reg("post_rst_cause", 3'd3, 8'hFF);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            for (int b = 0; b < NUM_SRC; b++)
                if ($urandom_range(0, 7) == 0) irq_src[b] = ~irq_src[b];
            port_id = 8'($urandom_range(8'h1E, 8'h29));
            write_strobe = ($urandom_range(0, 5) == 0);
            read_strobe = ($urandom_range(0, 3) == 0);
            data_in = 8'($urandom);
            if (port_id == BASE + 8'd4) data_in = 8'($urandom_range(0, 3));
            interrupt_ack = interrupt ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            step();
        end
        write_strobe = 1'b0;
        interrupt_ack = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/intr_sched.md
Name: intr_sched

Overview:
- Interrupt controller and scheduler between event sources and the KCPSM6 single interrupt/interrupt_ack pair.
- Sources are the RojoBot upd_sysregs, debounced button edges and an internal periodic timer.
- Latches each event as pending, applies a software mask and presents one prioritized interrupt at a time, holding it until acknowledged.
- Exposes mask, pending, cause and timer registers on the PicoBlaze port bus. Its read data is muxed into in_port by the I/O interface.

Parameters:
- NUM_SRC, 4, number of external sources (1..7). The internal timer occupies index NUM_SRC.
- BASE_ADDR, 8'h20, first port address of the register block (low 3 bits must be 0).
- PRESCALE, 100000, clk cycles per timer tick (1 ms at 100 MHz).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-low reset.
- irq_src  in  NUM_SRC  level inputs, synchronous to clk; a rising edge raises an event. Bit 0 is highest priority.
- port_id  in  8  PicoBlaze port address.
- data_in  in  8  PicoBlaze out_port.
- write_strobe  in  1  PicoBlaze write strobe.
- read_strobe  in  1  PicoBlaze read strobe.
- data_out  out  8  register read data, to the in_port mux.
- interrupt  out  1  to KCPSM6 interrupt.
- interrupt_ack  in  1  from KCPSM6.

Behaviour:
- Reset (rst=0, async):
  - interrupt=0, data_out=0, mask=0, pending=0, cause=8'hFF, period=0.
  - Prescaler, tick counter and edge-detect registers = 0; FSM=IDLE.
- Edge detect: event[i] = irq_src[i] & ~irq_src_q[i]. Timer event is a one-cycle pulse. All events are OR'd into pending each cycle.
- Timer:
  - Prescaler counts 0..PRESCALE-1 and wraps; each wrap increments the tick counter.
  - When tick counter == period-1, it clears to 0 and raises the timer event.
  - period=0 disables the timer and holds both counters at 0.
  - A write to period clears both counters.
- Register map (offset from BASE_ADDR):
  - +0 MASK, R/W. Bit=1 enables that source.
  - +1 PEND, R.
  - +2 CLR, W. Write-1-to-clear pending bits.
  - +3 CAUSE, R. Index of the last granted source; 8'hFF if none.
  - +4 PERIOD, R/W.
  - +5 LOST, R. Present only with the optional feature; otherwise reads 0.
  - +6 and +7 read 0 and ignore writes.
- Writes take effect on the clock edge where write_strobe=1 and port_id matches.
- data_out is registered every cycle from port_id: 1-cycle latency, valid on the KCPSM6 INPUT sample cycle. Addresses outside the block drive 0.
- Reads have no side effects.
- FSM:
  - IDLE: when (pending & mask)!=0, latch cause = lowest set index and go to ASSERT.
  - ASSERT: interrupt=1 on the following cycle. Stay until interrupt_ack=1.
  - On ack: interrupt=0 in the same registered edge, clear pending[cause], go to HOLDOFF.
  - HOLDOFF: one cycle, then IDLE. Guarantees at least one cycle low between interrupts.
- Once granted, cause is fixed. Masking or CLR of the granted source during ASSERT does not withdraw interrupt.
- Set wins over clear: an event arriving in the same cycle as a CLR write or ack-clear of the same bit leaves pending set.
- Repeated events on an already pending bit collapse into one pending bit.
- Reset mid-ASSERT drops interrupt asynchronously; nothing survives reset.

Optional Feature:
- Macro INTR_SCHED_LOST_CNT_EN.
- Defined:
  - 8-bit saturating LOST counter increments when an event hits a source whose pending bit is already set.
  - Multiple collisions in one cycle count once.
  - Any write to offset +5 clears it; readable at +5.
- Undefined: no counter logic; +5 reads 0.

Decomposition:
- Shared package intr_sched_pkg holds:
  - register offsets (OFF_MASK..OFF_LOST);
  - FSM state encoding (IDLE, ASSERT, HOLDOFF);
  - the CAUSE_NONE=8'hFF constant.
- One natural sub-module, intr_timer: prescaler, tick counter and period compare, emitting a one-cycle tick pulse.

Test Plan:
- Reset/readback: hold rst=0 with irq_src toggling, release → interrupt=0, all registers read 0 except CAUSE=8'hFF; MASK write 8'h1F reads back 8'h1F.
- Single event, MASK=8'h01: pulse irq_src[0] → PEND=8'h01, interrupt=1 within 3 cycles, CAUSE=0; ack → interrupt=0 next edge, PEND=0.
- Priority: MASK=8'h0F, rising edges on srcs 1 and 3 in the same cycle → first grant CAUSE=1; after ack and HOLDOFF, second grant CAUSE=3; interrupt low at least 1 cycle between them.
- Timer with PRESCALE=10 in sim, PERIOD=3, MASK=8'h10 → timer events every 30 cycles, CAUSE=4; PERIOD=0 → no further events.
- Set-vs-clear: CLR=8'h02 written in the same cycle as an irq_src[1] edge → PEND bit 1 remains 1.
- With INTR_SCHED_LOST_CNT_EN: 5 edges on src 2 while masked → PEND bit 2=1, LOST=4; write +5 → LOST=0.
